inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage. Sits directly upstream of the register-file/ALU datapath and supplies its 32-bit instruction word.
- Holds a program counter and indexes a fixed instruction ROM.
- Issues one instruction at a time to the datapath over a valid/ready handshake.
- Advances either by single-step pushbutton or by free-run at a divided rate.
- Halts on a dedicated HALT instruction.

Parameters:
DEPTH, 16, ROM words; PC wraps modulo DEPTH.
ADDR_W, 4, PC width; equals clog2(DEPTH).
DIV, 4, idle cycles between issues in run mode; minimum 1.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
run_i  in  1  1 = free-run mode, 0 = single-step mode
step_i  in  1  raw step pushbutton level; the block edge-detects it
jump_i  in  1  load PC from jump_addr_i
jump_addr_i  in  ADDR_W  jump target
inst_ready_i  in  1  downstream accepts inst_o
inst_o  out  32  instruction word
inst_valid_o  out  1  inst_o valid
pc_o  out  ADDR_W  address of current/next instruction
halted_o  out  1  HALT instruction accepted

Behaviour:
Reset (async, rst low):
- pc_o=0, inst_o=0, inst_valid_o=0, halted_o=0.
- State IDLE, divider=0, step edge flops=0.
- Takes effect immediately, including mid-ISSUE.

States: IDLE, ISSUE, HALT.

IDLE:
- trigger = rising edge of step_i, OR (run_i=1 AND divider==DIV-1).
- Divider increments each IDLE cycle while run_i=1. It holds at 0 while run_i=0.
- On trigger: next edge sets inst_o<=ROM[pc_o] and inst_valid_o<=1, then goes to ISSUE. Latency is 1 cycle from trigger.
- jump_i=1: pc_o<=jump_addr_i and divider<=0. jump_i beats a same-cycle trigger; that trigger is dropped.

ISSUE:
- inst_o and inst_valid_o are held stable until inst_ready_i=1.
- On the handshake cycle (valid & ready):
  - inst_o==HALT_INST: inst_valid_o<=0, halted_o<=1, go to HALT. pc_o is unchanged.
  - Otherwise: inst_valid_o<=0, pc_o<=(pc_o==DEPTH-1)?0:pc_o+1, divider<=0, go to IDLE.
- jump_i and step edges arriving during ISSUE are ignored.

HALT:
- inst_valid_o=0. Step edges and run_i are ignored.
- jump_i=1: pc_o<=jump_addr_i, halted_o<=0, go to IDLE.

Run-mode issue period with inst_ready_i tied high: DIV+1 cycles.

Step edge:
- A rising edge is the registered step level 0 followed by the current level 1.
- Exactly one trigger per press. A held button does not repeat.

Optional Feature:
FETCH_STEP_SYNC_EN
- Defined: step_i passes through a 2-flop synchronizer before edge detection. Trigger arrives 2 cycles later than without the macro.
- Undefined: step_i is edge-detected directly with a single history flop. Use only for simulation or already-synchronous sources.

Decomposition:
Package fetch_pkg holds:
- HALT_INST = 32'hFFFF_FFFF.
- State enum {IDLE, ISSUE, HALT}.
- ROM contents as a DEPTH-entry constant array. Words 0..2 are the test program, word 3 = HALT_INST, the rest are 0.

Sub-module step_edge: optional synchronizer plus rising-edge pulse generator.

Test Plan:
1. Reset, run_i=0, ready=1, one step pulse → one cycle later inst_valid_o=1 with inst_o=ROM[0]; next cycle valid=0 and pc_o=1.
2. run_i=1, DIV=4, ready=1 from reset → valid pulses every 5 cycles, carrying ROM[0], ROM[1], ROM[2], then HALT_INST; then halted_o=1 with pc_o=3 and no further valid.
3. Step with ready=0 for 3 cycles, then 1 → inst_o stable and pc_o unchanged for 3 cycles; accept on cycle 4, then pc_o increments.
4. In HALT: pulse jump_i with jump_addr_i=0 → halted_o=0, state IDLE, next step issues ROM[0].
5. jump_i to 15 (word 0, not HALT), then step → issues ROM[15]; pc_o wraps to 0. A jump coinciding with a step edge → jump taken, no issue.
6. Assert rst low mid-ISSUE → inst_valid_o=0 and pc_o=0 with no clock edge. Repeat with the macro on and off, checking a 2-cycle difference in step latency.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, state encoding and instruction ROM for inst_fetch
package fetch_pkg;

    localparam int          ROM_DEPTH = 16;
    localparam int          ROM_AW    = 4;
    localparam logic [31:0] HALT_INST = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Words 0..2 form the program, word 3 stops the fetcher, the remainder are zero.
    localparam logic [ROM_DEPTH-1:0][31:0] ROM = {
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
        HALT_INST,     32'h0F0F_F0F0, 32'hA5A5_0001, 32'h1234_5678
    };

    function automatic logic [31:0] rom_read(input logic [ROM_AW-1:0] addr);
        return ROM[addr];
    endfunction

endpackage

// File: rtl/step_edge.sv
// rtl/step_edge.sv - step button rising-edge pulse, optional 2-flop synchronizer (FETCH_STEP_SYNC_EN)
module step_edge (
    input  logic clk,
    input  logic rst,
    input  logic step_i,
    output logic pulse_o
);

    logic level;
    logic hist_q;

`ifdef FETCH_STEP_SYNC_EN
    logic [1:0] sync_q;

    // Two-stage synchronizer for the asynchronous pushbutton level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], step_i};
        end
    end

    assign level = sync_q[1];
`else
    assign level = step_i;
`endif

    // History flop: remembers last cycle's level so a held button yields one pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= level;
        end
    end

    assign pulse_o = level & ~hist_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: PC, ROM, valid/ready issue, step/run/halt control (FETCH_STEP_SYNC_EN)
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o
);

    localparam int DIV_W = $clog2(DIV) + 1;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              step_pulse;
    logic              trigger;

    step_edge u_step_edge (
        .clk     (clk),
        .rst     (rst),
        .step_i  (step_i),
        .pulse_o (step_pulse)
    );

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            div_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            div_q    <= div_d;
        end
    end

    // Next-state logic: trigger/jump arbitration in IDLE, handshake in ISSUE, jump-out of HALT.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        div_d    = div_q;
        trigger  = step_pulse | (run_i & (div_q == DIV_W'(DIV - 1)));

        case (state_q)
            IDLE: begin
                if (jump_i) begin
                    // A jump wins over any same-cycle trigger, which is simply lost.
                    pc_d  = jump_addr_i;
                    div_d = '0;
                end else if (trigger) begin
                    inst_d  = rom_read(ROM_AW'(pc_q));
                    valid_d = 1'b1;
                    div_d   = '0;
                    state_d = ISSUE;
                end else if (run_i) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                end
            end
            ISSUE: begin
                if (inst_ready_i) begin
                    valid_d = 1'b0;
                    if (inst_q == HALT_INST) begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end else begin
                        pc_d    = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + 1'b1;
                        div_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (jump_i) begin
                    pc_d     = jump_addr_i;
                    halted_d = 1'b0;
                    div_d    = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign pc_o         = pc_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard testbench for inst_fetch (FETCH_STEP_SYNC_EN aware)
module tb_inst_fetch;

    localparam logic [31:0] W0   = 32'h1234_5678;
    localparam logic [31:0] W1   = 32'hA5A5_0001;
    localparam logic [31:0] W2   = 32'h0F0F_F0F0;
    localparam logic [31:0] WH   = 32'hFFFF_FFFF;
    localparam logic [31:0] W15  = 32'h0000_0000;
`ifdef FETCH_STEP_SYNC_EN
    localparam int STEP_LAT = 3;
`else
    localparam int STEP_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run_i = 1'b0;
    logic        step_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [3:0]  jump_addr_i = 4'd0;
    logic        inst_ready_i = 1'b1;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [3:0]  pc_o;
    logic        halted_o;

    typedef struct packed {
        logic [31:0] inst;
        logic [3:0]  pc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    inst_fetch #(.DEPTH(16), .ADDR_W(4), .DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .run_i        (run_i),
        .step_i       (step_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o),
        .halted_o     (halted_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input string name);
        int n;
        n = 0;
        step_i = 1'b1;
        do begin
            cyc();
            n++;
            if (n == 1) step_i = 1'b0;
        end while (!inst_valid_o && n < 20);
        check(name, 32'(n), 32'(STEP_LAT));
    endtask

    // Monitor: every accepted instruction is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst && inst_valid_o && inst_ready_i) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got inst %h pc %0d with empty scoreboard", inst_o, pc_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("issue_inst", inst_o, e.inst);
                check("issue_pc", 32'(pc_o), 32'(e.pc));
            end
        end
    end

    initial begin
        int nvalid;
        int idx[4];

        #1;
        check("reset_pc", 32'(pc_o), 32'd0);
        check("reset_valid", 32'(inst_valid_o), 32'd0);
        check("reset_inst", inst_o, 32'd0);
        check("reset_halted", 32'(halted_o), 32'd0);
        cyc();
        cyc();
        rst = 1'b1;

        // Single step with ready high.
        q.push_back('{W0, 4'd0});
        press("t1_latency");
        check("t1_valid", 32'(inst_valid_o), 32'd1);
        check("t1_inst", inst_o, W0);
        cyc();
        check("t1_valid_drop", 32'(inst_valid_o), 32'd0);
        check("t1_pc", 32'(pc_o), 32'd1);

        // Backpressure: held stable for 3 cycles, accepted on the 4th.
        inst_ready_i = 1'b0;
        q.push_back('{W1, 4'd1});
        press("t3_latency");
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_hold_valid", 32'(inst_valid_o), 32'd1);
            check("t3_hold_inst", inst_o, W1);
            check("t3_hold_pc", 32'(pc_o), 32'd1);
        end
        inst_ready_i = 1'b1;
        cyc();
        check("t3_valid_after", 32'(inst_valid_o), 32'd0);
        check("t3_pc_after", 32'(pc_o), 32'd2);

        // Finish the program and hit HALT.
        q.push_back('{W2, 4'd2});
        press("w2_latency");
        cyc();
        check("w2_pc_after", 32'(pc_o), 32'd3);
        q.push_back('{WH, 4'd3});
        press("halt_latency");
        cyc();
        check("halt_halted", 32'(halted_o), 32'd1);
        check("halt_pc", 32'(pc_o), 32'd3);
        check("halt_valid", 32'(inst_valid_o), 32'd0);

        // Step presses are ignored while halted.
        step_i = 1'b1;
        cyc();
        step_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("halt_no_valid", 32'(inst_valid_o), 32'd0);
        end
        check("halt_still", 32'(halted_o), 32'd1);

        // Jump out of HALT to 0, then step.
        jump_addr_i = 4'd0;
        jump_i = 1'b1;
        cyc();
        jump_i = 1'b0;
        check("t4_unhalt", 32'(halted_o), 32'd0);
        check("t4_pc", 32'(pc_o), 32'd0);
        q.push_back('{W0, 4'd0});
        press("t4_latency");
        cyc();
        check("t4_pc_after", 32'(pc_o), 32'd1);

        // Jump to last word, issue it, PC wraps.
        jump_addr_i = 4'd15;
        jump_i = 1'b1;
        cyc();
        jump_i = 1'b0;
        check("t5_pc_jump", 32'(pc_o), 32'd15);
        q.push_back('{W15, 4'd15});
        press("t5_latency");
        cyc();
        check("t5_pc_wrap", 32'(pc_o), 32'd0);

        // Jump coinciding with the step pulse: jump taken, no issue.
        step_i = 1'b1;
        for (int k = 0; k < STEP_LAT - 1; k++) begin
            cyc();
            step_i = 1'b0;
        end
        jump_addr_i = 4'd5;
        jump_i = 1'b1;
        cyc();
        jump_i = 1'b0;
        step_i = 1'b0;
        check("t5_coincide_pc", 32'(pc_o), 32'd5);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("t5_coincide_no_valid", 32'(inst_valid_o), 32'd0);
        end

        // Free-run mode from reset: period DIV+1 = 5.
        rst = 1'b0;
        cyc();
        check("t2_reset_pc", 32'(pc_o), 32'd0);
        run_i = 1'b1;
        inst_ready_i = 1'b1;
        q.push_back('{W0, 4'd0});
        q.push_back('{W1, 4'd1});
        q.push_back('{W2, 4'd2});
        q.push_back('{WH, 4'd3});
        rst = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 4; i++) idx[i] = -1;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (inst_valid_o) begin
                if (nvalid < 4) idx[nvalid] = c;
                nvalid++;
            end
        end
        check("t2_issue0_cycle", 32'(idx[0]), 32'd4);
        check("t2_issue1_cycle", 32'(idx[1]), 32'd9);
        check("t2_issue2_cycle", 32'(idx[2]), 32'd14);
        check("t2_issue3_cycle", 32'(idx[3]), 32'd19);
        check("t2_issue_count", 32'(nvalid), 32'd4);
        check("t2_halted", 32'(halted_o), 32'd1);
        check("t2_pc", 32'(pc_o), 32'd3);

        // Asynchronous reset in the middle of an ISSUE.
        run_i = 1'b0;
        jump_addr_i = 4'd7;
        jump_i = 1'b1;
        cyc();
        jump_i = 1'b0;
        check("t6_pc_jump", 32'(pc_o), 32'd7);
        inst_ready_i = 1'b0;
        press("t6_latency");
        check("t6_in_issue", 32'(inst_valid_o), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_async_valid", 32'(inst_valid_o), 32'd0);
        check("t6_async_pc", 32'(pc_o), 32'd0);
        check("t6_async_inst", inst_o, 32'd0);
        check("t6_async_halted", 32'(halted_o), 32'd0);
        cyc();
        rst = 1'b1;
        inst_ready_i = 1'b1;
        cyc();

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
